vram_arbiter: RTL and testbench

Single-port frame-buffer arbiter between the VGA scan-out path and one drawing client (CPU/blitter). It sits between the 640x480 sync generator and a synchronous single-port RAM holding a 160x120 image (4x4 pixel replication). Every 4-clock pixel period, one RAM slot is reserved for the display fetch. The other slots are granted to the client through a req/gnt handshake.

---
 rtl/vram_arbiter_if.sv | 23 ++
 rtl/vram_arbiter.sv | 124 ++++++++++++
 tb/tb_vram_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// Client-side bus of the frame-buffer arbiter: request/grant handshake plus read return.
interface vram_arbiter_if #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 15
) ();
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port frame-buffer arbiter: one display fetch per visible pixel period,
// all remaining RAM cycles handed to a drawing client via req/gnt.
module vram_arbiter #(
    parameter int DATA_W   = 12,
    parameter int ADDR_W   = 15,
    parameter int FB_DEPTH = 19200
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pixel_tick,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              video_on,
    input  logic              vblank_only,
    vram_arbiter_if.slave     bus,
    output logic [DATA_W-1:0] rgb,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_RD_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic              disp_slot_q, disp_slot_d;
    logic              disp_rd_q, disp_rd_d;
    logic              rd_oor_q, rd_oor_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] rgb_q, rgb_d;

    logic              disp_slot;
    logic              client_ok;
    logic              in_range;
    logic              grant;
    logic [ADDR_W-1:0] x_cell;
    logic [ADDR_W-1:0] y_cell;
    logic [ADDR_W-1:0] disp_addr;

    // 160 words per image row; the multiply is folded into two shifts.
    assign x_cell    = ADDR_W'(x >> 2);
    assign y_cell    = ADDR_W'(y >> 2);
    assign disp_addr = (y_cell << 7) + (y_cell << 5) + x_cell;

    always_comb begin
        disp_slot = disp_slot_q & video_on & ~reset;
        client_ok = ~vblank_only | (y >= 10'd480);
        in_range  = bus.addr < ADDR_W'(FB_DEPTH);
        grant     = ~reset & (state_q == ST_IDLE) & bus.req & ~disp_slot & client_ok;

        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (disp_slot) begin
            ram_addr = disp_addr;
        end else if (grant) begin
            ram_addr = in_range ? bus.addr : '0;
            if (bus.we && in_range) begin
                ram_we    = 1'b1;
                ram_wdata = bus.wdata;
            end
        end

        state_d  = state_q;
        rd_oor_d = rd_oor_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (grant && !bus.we) begin
                    state_d  = ST_RD_WAIT;
                    rd_oor_d = ~in_range;
                end
            end
            ST_RD_WAIT: begin
                rvalid_d = 1'b1;
                rdata_d  = rd_oor_q ? '0 : ram_rdata;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        disp_slot_d = pixel_tick;
        disp_rd_d   = disp_slot;

        // Blank pixels force black instead of fetching.
        rgb_d = rgb_q;
        if (disp_rd_q) begin
            rgb_d = ram_rdata;
        end else if (disp_slot_q && !video_on) begin
            rgb_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            disp_slot_q <= 1'b0;
            disp_rd_q   <= 1'b0;
            rd_oor_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rgb_q       <= '0;
        end else begin
            state_q     <= state_d;
            disp_slot_q <= disp_slot_d;
            disp_rd_q   <= disp_rd_d;
            rd_oor_q    <= rd_oor_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            rgb_q       <= rgb_d;
        end
    end

    assign bus.gnt    = grant;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_q;
    assign rgb        = rgb_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: display fetch, collisions, reads, vblank gating, range checks.
module tb_vram_arbiter;
    localparam int DATA_W = 12;
    localparam int ADDR_W = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              pixel_tick;
    logic [9:0]        x;
    logic [9:0]        y;
    logic              video_on;
    logic              vblank_only;
    logic [DATA_W-1:0] rgb;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    int checks = 0;
    int errors = 0;
    int gcount;

    vram_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    vram_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FB_DEPTH(19200)) dut (
        .clk         (clk),
        .reset       (reset),
        .pixel_tick  (pixel_tick),
        .x           (x),
        .y           (y),
        .video_on    (video_on),
        .vblank_only (vblank_only),
        .bus         (bus),
        .rgb         (rgb),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic w, input logic [ADDR_W-1:0] a,
                                 input logic [DATA_W-1:0] d);
        bus.req   = r;
        bus.we    = w;
        bus.addr  = a;
        bus.wdata = d;
    endtask

    // Inputs for a cycle are driven 2ns after its rising edge, outputs sampled 1ns later.
    task automatic next_cycle;
        @(posedge clk);
        #2;
    endtask

    task automatic settle;
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        pixel_tick  = 1'b0;
        video_on    = 1'b0;
        vblank_only = 1'b0;
        x           = 10'd0;
        y           = 10'd0;
        ram_rdata   = '0;
        applyStimulus(1'b1, 1'b1, 15'd100, 12'h123);

        for (int i = 0; i < 2; i++) begin
            next_cycle();
            settle();
            checkOutput("rst_gnt", 32'(bus.gnt), 0);
            checkOutput("rst_ram_we", 32'(ram_we), 0);
            checkOutput("rst_rgb", 32'(rgb), 0);
            checkOutput("rst_rvalid", 32'(bus.rvalid), 0);
        end

        next_cycle();
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 15'd0, 12'h000);
        settle();
        checkOutput("post_rst_gnt", 32'(bus.gnt), 0);
        checkOutput("post_rst_rvalid", 32'(bus.rvalid), 0);
        checkOutput("post_rst_rdata", 32'(bus.rdata), 0);
        checkOutput("post_rst_rgb", 32'(rgb), 0);
        checkOutput("post_rst_ram_addr", 32'(ram_addr), 0);
        checkOutput("post_rst_ram_we", 32'(ram_we), 0);
        checkOutput("post_rst_ram_wdata", 32'(ram_wdata), 0);

        // Display fetch of pixel (4,8) -> word 2*160+1
        next_cycle();
        pixel_tick = 1'b1;
        video_on   = 1'b1;
        next_cycle();
        pixel_tick = 1'b0;
        x = 10'd4;
        y = 10'd8;
        settle();
        checkOutput("disp_addr", 32'(ram_addr), 321);
        checkOutput("disp_we", 32'(ram_we), 0);
        next_cycle();
        ram_rdata = 12'hABC;
        settle();
        checkOutput("disp_rgb_t2", 32'(rgb), 0);
        next_cycle();
        settle();
        checkOutput("disp_rgb_t3", 32'(rgb), 32'hABC);
        next_cycle();
        pixel_tick = 1'b1;
        settle();
        checkOutput("disp_rgb_hold", 32'(rgb), 32'hABC);
        next_cycle();
        pixel_tick = 1'b0;
        video_on   = 1'b0;
        settle();
        checkOutput("blank_ram_addr", 32'(ram_addr), 0);
        checkOutput("blank_rgb_lag", 32'(rgb), 32'hABC);
        next_cycle();
        settle();
        checkOutput("blank_rgb_black", 32'(rgb), 0);
        ram_rdata = '0;

        // Client write colliding with a display slot at (8,8) -> word 322
        next_cycle();
        pixel_tick = 1'b1;
        video_on   = 1'b1;
        x = 10'd8;
        next_cycle();
        pixel_tick = 1'b0;
        applyStimulus(1'b1, 1'b1, 15'd100, 12'h123);
        settle();
        checkOutput("coll_gnt_t1", 32'(bus.gnt), 0);
        checkOutput("coll_addr_t1", 32'(ram_addr), 322);
        checkOutput("coll_we_t1", 32'(ram_we), 0);
        next_cycle();
        settle();
        checkOutput("coll_gnt_t2", 32'(bus.gnt), 1);
        checkOutput("coll_we_t2", 32'(ram_we), 1);
        checkOutput("coll_addr_t2", 32'(ram_addr), 100);
        checkOutput("coll_wdata_t2", 32'(ram_wdata), 32'h123);
        next_cycle();
        applyStimulus(1'b0, 1'b0, 15'd0, 12'h000);
        settle();
        checkOutput("coll_gnt_t3", 32'(bus.gnt), 0);
        checkOutput("coll_we_t3", 32'(ram_we), 0);

        // Read, then a second read held through the RD_WAIT cycle
        next_cycle();
        applyStimulus(1'b1, 1'b0, 15'd5, 12'h000);
        settle();
        checkOutput("rd_gnt_g", 32'(bus.gnt), 1);
        checkOutput("rd_addr_g", 32'(ram_addr), 5);
        checkOutput("rd_we_g", 32'(ram_we), 0);
        next_cycle();
        ram_rdata = 12'h5A5;
        applyStimulus(1'b1, 1'b0, 15'd7, 12'h000);
        settle();
        checkOutput("rd_gnt_g1", 32'(bus.gnt), 0);
        checkOutput("rd_rvalid_g1", 32'(bus.rvalid), 0);
        next_cycle();
        ram_rdata = '0;
        settle();
        checkOutput("rd_rvalid_g2", 32'(bus.rvalid), 1);
        checkOutput("rd_rdata_g2", 32'(bus.rdata), 32'h5A5);
        checkOutput("rd2_gnt_g2", 32'(bus.gnt), 1);
        checkOutput("rd2_addr_g2", 32'(ram_addr), 7);
        next_cycle();
        applyStimulus(1'b0, 1'b0, 15'd0, 12'h000);
        ram_rdata = 12'h777;
        settle();
        checkOutput("rd_rvalid_pulse", 32'(bus.rvalid), 0);
        checkOutput("rd_rdata_hold", 32'(bus.rdata), 32'h5A5);
        next_cycle();
        ram_rdata = '0;
        settle();
        checkOutput("rd2_rvalid", 32'(bus.rvalid), 1);
        checkOutput("rd2_rdata", 32'(bus.rdata), 32'h777);
        next_cycle();
        settle();
        checkOutput("rd2_rvalid_end", 32'(bus.rvalid), 0);

        // Reset while a read is outstanding
        next_cycle();
        applyStimulus(1'b1, 1'b0, 15'd9, 12'h000);
        settle();
        checkOutput("rstrd_gnt", 32'(bus.gnt), 1);
        next_cycle();
        applyStimulus(1'b0, 1'b0, 15'd0, 12'h000);
        reset = 1'b1;
        ram_rdata = 12'h321;
        settle();
        checkOutput("rstrd_gnt_in_rst", 32'(bus.gnt), 0);
        next_cycle();
        reset = 1'b0;
        ram_rdata = '0;
        settle();
        checkOutput("rstrd_rvalid_a", 32'(bus.rvalid), 0);
        next_cycle();
        settle();
        checkOutput("rstrd_rvalid_b", 32'(bus.rvalid), 0);
        checkOutput("rstrd_rdata", 32'(bus.rdata), 0);

        // Out-of-range accesses and the last valid word
        next_cycle();
        applyStimulus(1'b1, 1'b1, 15'd19200, 12'h456);
        settle();
        checkOutput("oor_wr_gnt", 32'(bus.gnt), 1);
        checkOutput("oor_wr_we", 32'(ram_we), 0);
        next_cycle();
        applyStimulus(1'b1, 1'b1, 15'd19199, 12'h456);
        settle();
        checkOutput("last_wr_gnt", 32'(bus.gnt), 1);
        checkOutput("last_wr_we", 32'(ram_we), 1);
        checkOutput("last_wr_addr", 32'(ram_addr), 19199);
        next_cycle();
        applyStimulus(1'b1, 1'b0, 15'd19200, 12'h000);
        settle();
        checkOutput("oor_rd_gnt", 32'(bus.gnt), 1);
        checkOutput("oor_rd_addr", 32'(ram_addr), 0);
        next_cycle();
        applyStimulus(1'b0, 1'b0, 15'd0, 12'h000);
        ram_rdata = 12'hFFF;
        next_cycle();
        ram_rdata = '0;
        settle();
        checkOutput("oor_rd_rvalid", 32'(bus.rvalid), 1);
        checkOutput("oor_rd_rdata", 32'(bus.rdata), 0);

        // vblank_only: a whole visible line at y=100 must never grant
        next_cycle();
        vblank_only = 1'b1;
        y = 10'd100;
        applyStimulus(1'b1, 1'b1, 15'd300, 12'h0AA);
        gcount = 0;
        for (int p = 0; p < 800; p++) begin
            for (int k = 0; k < 4; k++) begin
                if (p != 0 || k != 0) next_cycle();
                x          = 10'(p);
                video_on   = (p < 640);
                pixel_tick = (k == 3);
                settle();
                if (bus.gnt === 1'b1) gcount++;
            end
        end
        checkOutput("vblank_line_gnt_count", 32'(gcount), 0);
        next_cycle();
        pixel_tick = 1'b0;
        video_on   = 1'b0;
        y = 10'd479;
        settle();
        checkOutput("vblank_y479_gnt", 32'(bus.gnt), 0);

        // y=480: four queued writes go out back to back, tick included
        next_cycle();
        y = 10'd480;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) next_cycle();
            applyStimulus(1'b1, 1'b1, ADDR_W'(200 + i), DATA_W'(12'h100 + i));
            pixel_tick = (i == 0);
            settle();
            checkOutput("vblank_burst_gnt", 32'(bus.gnt), 1);
            checkOutput("vblank_burst_we", 32'(ram_we), 1);
            checkOutput("vblank_burst_addr", 32'(ram_addr), 32'(200 + i));
        end
        next_cycle();
        applyStimulus(1'b0, 1'b0, 15'd0, 12'h000);
        pixel_tick  = 1'b0;
        vblank_only = 1'b0;
        settle();
        checkOutput("vblank_burst_end_gnt", 32'(bus.gnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
